// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin share of one AXI4 read channel between instruction fetch (port 0) and data load (port 1)
module axi_rd_arbiter #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              req_valid,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [13:0]             req_len,
   output logic [1:0]              req_ready,
   output logic [DATA_WIDTH-1:0]   rsp_data,
   output logic [1:0]              rsp_valid,
   output logic [1:0]              rsp_last,
   output logic                    rsp_err,
   output logic                    len_err,
   output logic                    busy,
   output logic [ID_WIDTH-1:0]     arid_m_inf,
   output logic [ADDR_WIDTH-1:0]   araddr_m_inf,
   output logic [6:0]              arlen_m_inf,
   output logic [2:0]              arsize_m_inf,
   output logic [1:0]              arburst_m_inf,
   output logic                    arvalid_m_inf,
   input  logic                    arready_m_inf,
   input  logic [ID_WIDTH-1:0]     rid_m_inf,
   input  logic [DATA_WIDTH-1:0]   rdata_m_inf,
   input  logic [1:0]              rresp_m_inf,
   input  logic                    rlast_m_inf,
   input  logic                    rvalid_m_inf,
   output logic                    rready_m_inf
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
   state_t r_state, w_next;
   logic                  r_owner, r_last_grant, r_len_err;
   logic [ADDR_WIDTH-1:0] r_araddr;
   logic [6:0]            r_arlen, r_cnt;
   logic                  w_win, w_ar_hs, w_beat, w_len_bad, w_unused;
   logic [1:0]            w_own;
   assign w_win     = &req_valid ? ~r_last_grant : req_valid[1];
   assign w_ar_hs   = (r_state == ADDR) & arready_m_inf;
   assign w_beat    = (r_state == DATA) & rvalid_m_inf;
   assign w_own     = r_owner ? 2'b10 : 2'b01;
   // early rlast, or the expected last beat arriving without rlast
   assign w_len_bad = w_beat & (rlast_m_inf ? (r_cnt != r_arlen) : (r_cnt == r_arlen));
   assign w_unused  = ^rid_m_inf;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (|req_valid) w_next = ADDR;
         ADDR:    if (w_ar_hs) w_next = DATA;
         DATA:    if (w_beat & rlast_m_inf) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_len_err    <= 1'b0;
         r_araddr     <= '0;
         r_arlen      <= '0;
         r_cnt        <= '0;
      end else begin
         r_state   <= w_next;
         r_len_err <= w_len_bad;
         if (r_state == IDLE && |req_valid) begin
            r_owner  <= w_win;
            r_araddr <= w_win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
            r_arlen  <= w_win ? req_len[13:7] : req_len[6:0];
         end
         if (w_ar_hs) begin
            r_last_grant <= r_owner;
            r_cnt        <= '0;
         end else if (w_beat && r_cnt != 7'h7f) begin
            r_cnt <= r_cnt + 7'd1;
         end
      end
   end
   assign req_ready     = {2{w_ar_hs}} & w_own;
   assign rsp_data      = (r_state == DATA) ? rdata_m_inf : '0;
   assign rsp_valid     = {2{w_beat}} & w_own;
   assign rsp_last      = {2{w_beat & rlast_m_inf}} & w_own;
   assign rsp_err       = w_beat & (|rresp_m_inf);
   assign len_err       = r_len_err;
   assign busy          = r_state != IDLE;
   assign arid_m_inf    = {{(ID_WIDTH-1){1'b0}}, r_owner};
   assign araddr_m_inf  = r_araddr;
   assign arlen_m_inf   = r_arlen;
   assign arsize_m_inf  = 3'b001;
   assign arburst_m_inf = 2'b01;
   assign arvalid_m_inf = r_state == ADDR;
   assign rready_m_inf  = r_state == DATA;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: table-driven, directed and randomized model-checked bench for axi_rd_arbiter
module tb_axi_rd_arbiter;
   logic        clk = 1'b0, rst = 1'b1;
   logic [1:0]  req_valid = '0;
   logic [63:0] req_addr = '0;
   logic [13:0] req_len = '0;
   logic [1:0]  req_ready, rsp_valid, rsp_last, arburst, rresp = '0;
   logic [15:0] rsp_data, rdata = '0;
   logic        rsp_err, len_err, busy, arvalid, arready = 1'b0, rlast = 1'b0, rvalid = 1'b0, rready;
   logic [3:0]  arid, rid = '0;
   logic [31:0] araddr;
   logic [6:0]  arlen;
   logic [2:0]  arsize;
   int          n_chk = 0, n_err = 0;

   axi_rd_arbiter dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
      .req_ready(req_ready), .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_last(rsp_last),
      .rsp_err(rsp_err), .len_err(len_err), .busy(busy), .arid_m_inf(arid), .araddr_m_inf(araddr),
      .arlen_m_inf(arlen), .arsize_m_inf(arsize), .arburst_m_inf(arburst), .arvalid_m_inf(arvalid),
      .arready_m_inf(arready), .rid_m_inf(rid), .rdata_m_inf(rdata), .rresp_m_inf(rresp),
      .rlast_m_inf(rlast), .rvalid_m_inf(rvalid), .rready_m_inf(rready)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   typedef struct {
      logic [1:0]  rv;
      logic [31:0] a0, a1;
      logic [6:0]  l0, l1;
      logic [1:0]  ex_rdy;
      logic [31:0] ex_addr;
      logic [6:0]  ex_len;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic nxt;
      @(negedge clk);
   endtask

   task automatic req(input logic [1:0] rv, input logic [31:0] a0, a1, input logic [6:0] l0, l1);
      nxt;
      rvalid = 0; rlast = 0; rresp = 0;
      req_valid = rv; req_addr = {a1, a0}; req_len = {l1, l0};
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_arvalid", arvalid, 0);
   endtask

   task automatic grant(input logic [1:0] own, input logic [31:0] ad, input logic [6:0] ln);
      nxt;
      arready = 1;
      #1;
      chk("arvalid", arvalid, 1);
      chk("arid", arid, {3'b0, own[1]});
      chk("araddr", araddr, ad);
      chk("arlen", arlen, ln);
      chk("arsize", arsize, 1);
      chk("arburst", arburst, 1);
      chk("req_ready", req_ready, own);
      chk("ar_busy", busy, 1);
      nxt;
      arready = 0;
      req_valid = req_valid & ~own;
      #1;
      chk("rready", rready, 1);
      chk("rsp_valid_gap", rsp_valid, 0);
      chk("req_ready_after", req_ready, 0);
   endtask

   task automatic beat(input logic lst, input logic [1:0] rsp, input logic [1:0] own);
      nxt;
      rvalid = 1; rlast = lst; rresp = rsp; rdata = 16'($urandom);
      #1;
      chk("rsp_valid", rsp_valid, own);
      chk("rsp_last", rsp_last, lst ? own : 2'b00);
      chk("rsp_err", rsp_err, rsp != 0);
      chk("rsp_data", rsp_data, rdata);
   endtask

   logic        m_act, m_gnt, m_port, m_last, m_lerr;
   logic [31:0] m_addr, ra[2];
   logic [6:0]  m_len, rl[2];
   int          m_beats;
   logic [1:0]  drop, e_own;

   initial begin
      tbl[0] = '{2'b11, 32'h100,  32'h200,  7'd0, 7'd0, 2'b01, 32'h100,  7'd0};
      tbl[1] = '{2'b01, 32'h1000, 32'h2000, 7'd7, 7'd2, 2'b01, 32'h1000, 7'd7};
      tbl[2] = '{2'b11, 32'h110,  32'h210,  7'd0, 7'd0, 2'b10, 32'h210,  7'd0};
      tbl[3] = '{2'b11, 32'h120,  32'h220,  7'd0, 7'd0, 2'b01, 32'h120,  7'd0};
      tbl[4] = '{2'b11, 32'h130,  32'h230,  7'd0, 7'd0, 2'b10, 32'h230,  7'd0};
      tbl[5] = '{2'b10, 32'h140,  32'h240,  7'd5, 7'd3, 2'b10, 32'h240,  7'd3};
      tbl[6] = '{2'b11, 32'h150,  32'h250,  7'd1, 7'd4, 2'b01, 32'h150,  7'd1};
      tbl[7] = '{2'b01, 32'h160,  32'h260,  7'd2, 7'd0, 2'b01, 32'h160,  7'd2};
      nxt;
      nxt;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_araddr", araddr, 0);
      chk("rst_arlen", arlen, 0);
      chk("rst_arid", arid, 0);
      chk("rst_rready", rready, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_len_err", len_err, 0);
      rst = 0;
      for (int i = 0; i < 8; i++) begin
         req(tbl[i].rv, tbl[i].a0, tbl[i].a1, tbl[i].l0, tbl[i].l1);
         chk("tbl_len_err", len_err, 0);
         grant(tbl[i].ex_rdy, tbl[i].ex_addr, tbl[i].ex_len);
         for (int b = 0; b <= int'(tbl[i].ex_len); b++) beat(b == int'(tbl[i].ex_len), 2'b00, tbl[i].ex_rdy);
      end
      // arready held off for five cycles
      req(2'b10, 0, 32'h3000, 0, 7'd2);
      for (int k = 0; k < 5; k++) begin
         nxt;
         #1;
         chk("stall_arvalid", arvalid, 1);
         chk("stall_araddr", araddr, 32'h3000);
         chk("stall_arlen", arlen, 2);
         chk("stall_req_ready", req_ready, 0);
      end
      grant(2'b10, 32'h3000, 7'd2);
      for (int b = 0; b < 3; b++) beat(b == 2, 2'b00, 2'b10);
      // premature rlast
      req(2'b01, 32'h4000, 0, 7'd3, 0);
      chk("ok_len_err", len_err, 0);
      grant(2'b01, 32'h4000, 7'd3);
      beat(0, 2'b00, 2'b01);
      beat(1, 2'b00, 2'b01);
      req(2'b10, 0, 32'h5000, 0, 0);
      chk("early_len_err", len_err, 1);
      grant(2'b10, 32'h5000, 7'd0);
      beat(1, 2'b00, 2'b10);
      // missing rlast, then late rlast
      req(2'b01, 32'h6000, 0, 7'd1, 0);
      chk("after_early_len_err", len_err, 0);
      grant(2'b01, 32'h6000, 7'd1);
      beat(0, 2'b00, 2'b01);
      beat(0, 2'b00, 2'b01);
      beat(1, 2'b00, 2'b01);
      chk("missing_len_err", len_err, 1);
      chk("missing_busy", busy, 1);
      // error response on beat 2 of 4
      req(2'b10, 0, 32'h7000, 0, 7'd3);
      chk("late_len_err", len_err, 1);
      grant(2'b10, 32'h7000, 7'd3);
      beat(0, 2'b00, 2'b10);
      beat(0, 2'b10, 2'b10);
      beat(0, 2'b00, 2'b10);
      beat(1, 2'b00, 2'b10);
      // reset in the middle of a burst
      req(2'b01, 32'h8000, 0, 7'd5, 0);
      chk("resp_len_err", len_err, 0);
      grant(2'b01, 32'h8000, 7'd5);
      beat(0, 2'b00, 2'b01);
      beat(0, 2'b00, 2'b01);
      nxt;
      rst = 1; rvalid = 1; rlast = 0;
      nxt;
      rst = 0; rresp = 2'b10;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rready", rready, 0);
      chk("mid_rst_arvalid", arvalid, 0);
      chk("mid_rst_araddr", araddr, 0);
      chk("mid_rst_arlen", arlen, 0);
      chk("mid_rst_arid", arid, 0);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_rsp_err", rsp_err, 0);
      chk("mid_rst_rsp_data", rsp_data, 0);
      chk("mid_rst_len_err", len_err, 0);
      req(2'b10, 0, 32'h9000, 0, 7'd1);
      grant(2'b10, 32'h9000, 7'd1);
      beat(0, 2'b00, 2'b10);
      beat(1, 2'b00, 2'b10);
      // randomized traffic against a burst-level model
      nxt;
      rst = 1; req_valid = 0; rvalid = 0; arready = 0; rlast = 0; rresp = 0;
      nxt;
      rst = 0;
      m_act = 0; m_gnt = 0; m_port = 0; m_last = 1; m_lerr = 0; m_beats = 0;
      m_addr = 0; m_len = 0; drop = 0;
      ra[0] = 0; ra[1] = 0; rl[0] = 0; rl[1] = 0;
      for (int c = 0; c < 4000; c++) begin
         nxt;
         req_valid = req_valid & ~drop;
         drop = 0;
         for (int p = 0; p < 2; p++)
            if (!req_valid[p] && $urandom_range(0, 3) == 0) begin
               req_valid[p] = 1;
               ra[p] = $urandom & ~32'h1;
               rl[p] = 7'($urandom_range(0, 5));
            end
         req_addr = {ra[1], ra[0]};
         req_len = {rl[1], rl[0]};
         arready = 1'($urandom_range(0, 1));
         rvalid = $urandom_range(0, 9) < 6;
         rdata = 16'($urandom);
         rresp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         if (m_act && m_gnt)
            rlast = (m_beats >= int'(m_len)) ? ($urandom_range(0, 9) != 0 || m_beats > int'(m_len) + 1)
                                             : ($urandom_range(0, 19) == 0);
         else
            rlast = 1'($urandom_range(0, 1));
         #1;
         e_own = m_port ? 2'b10 : 2'b01;
         chk("r_busy", busy, m_act);
         chk("r_arvalid", arvalid, m_act & !m_gnt);
         chk("r_rready", rready, m_act & m_gnt);
         chk("r_req_ready", req_ready, (m_act && !m_gnt && arready) ? e_own : 2'b00);
         chk("r_rsp_valid", rsp_valid, (m_act && m_gnt && rvalid) ? e_own : 2'b00);
         chk("r_rsp_last", rsp_last, (m_act && m_gnt && rvalid && rlast) ? e_own : 2'b00);
         chk("r_rsp_err", rsp_err, m_act && m_gnt && rvalid && rresp != 0);
         chk("r_rsp_data", rsp_data, (m_act && m_gnt) ? rdata : 16'h0);
         chk("r_len_err", len_err, m_lerr);
         if (m_act && !m_gnt) begin
            chk("r_araddr", araddr, m_addr);
            chk("r_arlen", arlen, m_len);
            chk("r_arid", arid, {3'b0, m_port});
         end
         m_lerr = 0;
         if (!m_act) begin
            if (|req_valid) begin
               m_port = &req_valid ? !m_last : req_valid[1];
               m_addr = ra[m_port];
               m_len = rl[m_port];
               m_act = 1;
               m_gnt = 0;
            end
         end else if (!m_gnt) begin
            if (arready) begin
               m_gnt = 1;
               m_beats = 0;
               m_last = m_port;
               drop[m_port] = 1;
            end
         end else if (rvalid) begin
            m_lerr = rlast ? (m_beats != int'(m_len)) : (m_beats == int'(m_len));
            if (m_beats < 127) m_beats++;
            if (rlast) m_act = 0;
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Shares one AXI4 read channel (AR + R) between two burst requesters: port 0 is the instruction fetch and port 1 is the data load. It sits between the CPU's fetch/load units and a DRAM read interface. It arbitrates round-robin, keeps one burst outstanding at a time, and routes returning beats to the owner. It also flags protocol anomalies (error response, premature or missing `rlast`).

## Interface
Parameters:
- `ID_WIDTH`, 4, AXI ID width
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 16, beat width; `arsize` fixed to 3'b001

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  2  per-port burst request; held until `req_ready`
- `req_addr`  in  2*ADDR_WIDTH  start address; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- `req_len`  in  2*7  beats minus 1 (AXI `arlen` encoding); port i at [i*7 +: 7]
- `req_ready`  out  2  one-cycle pulse when the port's AR handshake completes
- `rsp_data`  out  DATA_WIDTH  `rdata` passthrough
- `rsp_valid`  out  2  beat valid, owner port only
- `rsp_last`  out  2  final beat of burst, owner port only
- `rsp_err`  out  1  current beat has `rresp` != 0
- `len_err`  out  1  one-cycle pulse when a beat-count / `rlast` mismatch is seen
- `busy`  out  1  state != IDLE
- `arid_m_inf`  out  ID_WIDTH  {0, owner}
- `araddr_m_inf`  out  ADDR_WIDTH
- `arlen_m_inf`  out  7
- `arsize_m_inf`  out  3  constant 3'b001
- `arburst_m_inf`  out  2  constant 2'b01 (INCR)
- `arvalid_m_inf`  out  1
- `arready_m_inf`  in  1
- `rid_m_inf`  in  ID_WIDTH  ignored
- `rdata_m_inf`  in  DATA_WIDTH
- `rresp_m_inf`  in  2
- `rlast_m_inf`  in  1
- `rvalid_m_inf`  in  1
- `rready_m_inf`  out  1

## Operation
- FSM states:
  - IDLE to ADDR when any `req_valid` is high.
  - ADDR to DATA on `arvalid & arready`.
  - DATA to IDLE on `rvalid & rready & rlast`.
- Arbitration in IDLE:
  - Only one requester valid: it wins.
  - Both valid: the port not granted last time wins.
  - `last_grant` resets to 1, so port 0 wins the first tie.
- On the IDLE to ADDR transition, register `owner`, `araddr`, `arlen` from the winner. Registered AR outputs stay stable for the whole of ADDR.
- `req_ready[owner]` = `arvalid & arready` (combinational). Its rising edge updates `last_grant <= owner`. The requester may change `req_addr`/`req_len` after this cycle.
- DATA state:
  - `rready_m_inf` = 1; no backpressure toward requesters.
  - `rsp_valid[owner]` = `rvalid`; `rsp_last[owner]` = `rvalid & rlast`.
  - `rsp_err` = `rvalid & (rresp != 0)`.
  - Non-owner bits are 0.
- Beat counter `cnt` (7 bits) clears on entering DATA and increments per accepted beat.
- `len_err` pulses, registered (cycle after the offending beat), in either case:
  - `rlast` arrives with `cnt != arlen`; the burst still ends.
  - A beat arrives with `cnt == arlen` and `rlast == 0`. In this case stay in DATA until `rlast`; `cnt` saturates at 127.
- Outside DATA: `rready` = 0 and `rsp_*` = 0. Stray `rvalid` is ignored.
- `req_valid` dropped while in ADDR: illegal; the burst proceeds regardless.

## Timing
- Reset values: state IDLE, `arvalid` 0, `araddr` 0, `arlen` 0, `arid` 0, `rready` 0, `req_ready` 0, `rsp_*` 0, `len_err` 0, `busy` 0, `last_grant` 1, `cnt` 0.
- `req_valid` sampled high in IDLE at cycle t: `arvalid` high at t+1.
- `arready` already high at t+1: `req_ready` pulses at t+1, and `rready` is high from t+2.
- Beat forwarding is zero-latency: combinational from `rvalid`/`rdata`.
- Final beat at cycle u: state is IDLE at u+1, and the next `arvalid` is at u+2 at the earliest. This is a one-cycle bubble between bursts.
- `rst` high at any cycle forces reset values at the next edge, including mid-ADDR or mid-DATA. The aborted burst is not reported; the slave model must be reset with it.

## Test plan
- Single port-0 request, addr 0x1000, len 7, `arready` immediate: `arvalid` one cycle after `req_valid`; `arid` 0, `arlen` 7, `arsize` 1, `arburst` 1; 8 beats on `rsp_valid[0]`; `rsp_last[0]` on beat 8; `busy` drops the cycle after.
- Both ports request continuously, len 0 each: grants alternate 0, 1, 0, 1; `arid` alternates 0/1; exactly one idle cycle between bursts.
- `arready` held low for 5 cycles: `araddr`/`arlen`/`arvalid` stable throughout; `req_ready` pulses only on the handshake cycle.
- Burst len 3 with `rlast` on beat 2: burst ends, `len_err` pulses, next request served normally. Burst len 1 with no `rlast` on beat 2 and `rlast` on beat 3: `len_err` pulses after beat 2.
- `rresp` = 2'b10 on beat 2 of 4: `rsp_err` high only that beat; data still forwarded.
- `rst` asserted mid-DATA: next cycle all outputs at reset values, `rready` 0; a subsequent port-1-only request is granted with `arid` 1.
